alu_bist: RTL and testbench

- Built-in self-test controller for the processor ALU.
- Drives func/dataIn1/dataIn2 into the ALU from an external vector ROM, waits for the outputs to settle, then captures dataOut/compTrue and compares them against expected values.
- Reports pass/fail, error count and the first failing vector index.
- Sits beside the ALU in the datapath and is muxed onto the ALU inputs during test mode.

---
 rtl/alu_bist_if.sv | 31 +++
 rtl/alu_bist.sv | 176 +++++++++++++++++
 tb/tb_alu_bist.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_bist_if.sv
// Vector-ROM and ALU-side bus of the ALU BIST controller.
// master = BIST controller; slave = ROM/ALU side.
interface alu_bist_if #(
    parameter int DBITS    = 32,
    parameter int IDX_BITS = 4
);
    logic [IDX_BITS-1:0] vec_idx;
    logic [4:0]          vec_func;
    logic [DBITS-1:0]    vec_a;
    logic [DBITS-1:0]    vec_b;
    logic [DBITS-1:0]    vec_exp_out;
    logic                vec_exp_cmp;
    logic                vec_chk_out;
    logic [4:0]          alu_func;
    logic [DBITS-1:0]    alu_a;
    logic [DBITS-1:0]    alu_b;
    logic [DBITS-1:0]    alu_out;
    logic                alu_cmp;

    modport master (
        output vec_idx, alu_func, alu_a, alu_b,
        input  vec_func, vec_a, vec_b, vec_exp_out, vec_exp_cmp, vec_chk_out,
        input  alu_out, alu_cmp
    );

    modport slave (
        input  vec_idx, alu_func, alu_a, alu_b,
        output vec_func, vec_a, vec_b, vec_exp_out, vec_exp_cmp, vec_chk_out,
        output alu_out, alu_cmp
    );
endinterface

// File: rtl/alu_bist.sv
// ALU built-in self-test controller: replays ROM vectors into the ALU and checks results.
// Optional macro ALU_BIST_STOP_ON_FAIL_EN ends the run at the first mismatching vector.
//
// state | meaning
// IDLE  | waiting for start after reset
// FETCH | ROM address stable, ROM data arrives next cycle
// LATCH | vector captured onto ALU inputs, settle counter loaded
// WAIT  | settle counter running down to terminal count
// CHECK | ALU result compared against expectation
// DONE  | run finished, results held until next start
module alu_bist #(
    parameter int DBITS    = 32,
    parameter int IDX_BITS = 4,
    parameter int NUM_VEC  = 16,
    parameter int SETTLE   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    alu_bist_if.master          bus,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [7:0]          err_count,
    output logic [IDX_BITS-1:0] fail_idx
);
    localparam int CNT_BITS = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_VEC - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LATCH = 3'd2,
        WAIT  = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t              state,     stateNext;
    logic [IDX_BITS-1:0] vecIdx,    vecIdxNext;
    logic [4:0]          aluFunc,   aluFuncNext;
    logic [DBITS-1:0]    aluA,      aluANext;
    logic [DBITS-1:0]    aluB,      aluBNext;
    logic [DBITS-1:0]    expOut,    expOutNext;
    logic                expCmp,    expCmpNext;
    logic                expChk,    expChkNext;
    logic [CNT_BITS-1:0] settleCnt, settleCntNext;
    logic [7:0]          errCount,  errCountNext;
    logic [IDX_BITS-1:0] failIdx,   failIdxNext;
    logic                busyR,     busyNext;
    logic                doneR,     doneNext;
    logic                passR,     passNext;

    logic       mismatch;
    logic       stopNow;
    logic [7:0] errUpd;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            vecIdx    <= '0;
            aluFunc   <= '0;
            aluA      <= '0;
            aluB      <= '0;
            expOut    <= '0;
            expCmp    <= 1'b0;
            expChk    <= 1'b0;
            settleCnt <= '0;
            errCount  <= '0;
            failIdx   <= '0;
            busyR     <= 1'b0;
            doneR     <= 1'b0;
            passR     <= 1'b0;
        end else begin
            state     <= stateNext;
            vecIdx    <= vecIdxNext;
            aluFunc   <= aluFuncNext;
            aluA      <= aluANext;
            aluB      <= aluBNext;
            expOut    <= expOutNext;
            expCmp    <= expCmpNext;
            expChk    <= expChkNext;
            settleCnt <= settleCntNext;
            errCount  <= errCountNext;
            failIdx   <= failIdxNext;
            busyR     <= busyNext;
            doneR     <= doneNext;
            passR     <= passNext;
        end
    end

    // Branch ops leave dataOut undefined, so only compTrue is checked when expChk is low.
    assign mismatch = (bus.alu_cmp != expCmp) || (expChk && (bus.alu_out != expOut));
    assign errUpd   = (mismatch && (errCount != 8'hFF)) ? errCount + 8'd1 : errCount;

`ifdef ALU_BIST_STOP_ON_FAIL_EN
    assign stopNow = mismatch;
`else
    assign stopNow = 1'b0;
`endif

    always_comb begin
        stateNext     = state;
        vecIdxNext    = vecIdx;
        aluFuncNext   = aluFunc;
        aluANext      = aluA;
        aluBNext      = aluB;
        expOutNext    = expOut;
        expCmpNext    = expCmp;
        expChkNext    = expChk;
        settleCntNext = settleCnt;
        errCountNext  = errCount;
        failIdxNext   = failIdx;
        busyNext      = busyR;
        doneNext      = doneR;
        passNext      = passR;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    stateNext    = FETCH;
                    vecIdxNext   = '0;
                    errCountNext = '0;
                    failIdxNext  = '0;
                    busyNext     = 1'b1;
                    doneNext     = 1'b0;
                    passNext     = 1'b0;
                end
            end
            FETCH: stateNext = LATCH;
            LATCH: begin
                aluFuncNext   = bus.vec_func;
                aluANext      = bus.vec_a;
                aluBNext      = bus.vec_b;
                expOutNext    = bus.vec_exp_out;
                expCmpNext    = bus.vec_exp_cmp;
                expChkNext    = bus.vec_chk_out;
                settleCntNext = CNT_BITS'(SETTLE);
                stateNext     = WAIT;
            end
            WAIT: begin
                if (settleCnt == CNT_BITS'(1)) begin
                    stateNext = CHECK;
                end else begin
                    settleCntNext = settleCnt - CNT_BITS'(1);
                end
            end
            CHECK: begin
                errCountNext = errUpd;
                if (mismatch && (errCount == 8'd0)) begin
                    failIdxNext = vecIdx;
                end
                if (stopNow || (vecIdx == LAST_IDX)) begin
                    stateNext = DONE;
                    busyNext  = 1'b0;
                    doneNext  = 1'b1;
                    passNext  = (errUpd == 8'd0);
                end else begin
                    vecIdxNext = vecIdx + IDX_BITS'(1);
                    stateNext  = FETCH;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign bus.vec_idx  = vecIdx;
    assign bus.alu_func = aluFunc;
    assign bus.alu_a    = aluA;
    assign bus.alu_b    = aluB;
    assign busy         = busyR;
    assign done         = doneR;
    assign pass         = passR;
    assign err_count    = errCount;
    assign fail_idx     = failIdx;
endmodule

// File: tb/tb_alu_bist.sv
// Directed bench for alu_bist: a 4-vector instance with a small ALU/ROM model,
// plus a 300-vector instance exercising error-count saturation.
module tb_alu_bist;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       startS, startL;
    logic       busyS, doneS, passS;
    logic [7:0] errS;
    logic [3:0] failS;
    logic       busyL, doneL, passL;
    logic [7:0] errL;
    logic [8:0] failL;

    int checks = 0;
    int errors = 0;

`ifdef ALU_BIST_STOP_ON_FAIL_EN
    localparam int FAIL_CYC = 12;
    localparam int SAT_CYC  = 4;
    localparam int SAT_ERR  = 1;
`else
    localparam int FAIL_CYC = 16;
    localparam int SAT_CYC  = 1200;
    localparam int SAT_ERR  = 255;
`endif

    alu_bist_if #(.DBITS(32), .IDX_BITS(4)) busS ();
    alu_bist_if #(.DBITS(32), .IDX_BITS(9)) busL ();

    alu_bist #(.DBITS(32), .IDX_BITS(4), .NUM_VEC(4), .SETTLE(1)) dutS (
        .clk(clk), .rst_n(rst_n), .start(startS), .bus(busS),
        .busy(busyS), .done(doneS), .pass(passS), .err_count(errS), .fail_idx(failS)
    );

    alu_bist #(.DBITS(32), .IDX_BITS(9), .NUM_VEC(300), .SETTLE(1)) dutL (
        .clk(clk), .rst_n(rst_n), .start(startL), .bus(busL),
        .busy(busyL), .done(doneL), .pass(passL), .err_count(errL), .fail_idx(failL)
    );

    // Reference ALU: add, sub, BEQ (dataOut 0 for branches)
    function automatic logic [31:0] aluOut(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            5'd0:     return a + b;
            5'd1:     return a - b;
            default:  return 32'd0;
        endcase
    endfunction

    function automatic logic aluCmp(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
        return (f == 5'b10001) ? (a == b) : 1'b0;
    endfunction

    logic [4:0]  romFunc [4];
    logic [31:0] romA    [4];
    logic [31:0] romB    [4];
    logic [31:0] romExp  [4];
    logic        romCmp  [4];
    logic        romChk  [4];

    always @(posedge clk) begin
        busS.vec_func    <= romFunc[busS.vec_idx[1:0]];
        busS.vec_a       <= romA[busS.vec_idx[1:0]];
        busS.vec_b       <= romB[busS.vec_idx[1:0]];
        busS.vec_exp_out <= romExp[busS.vec_idx[1:0]];
        busS.vec_exp_cmp <= romCmp[busS.vec_idx[1:0]];
        busS.vec_chk_out <= romChk[busS.vec_idx[1:0]];
    end

    always_comb begin
        busS.alu_out = aluOut(busS.alu_func, busS.alu_a, busS.alu_b);
        busS.alu_cmp = aluCmp(busS.alu_func, busS.alu_a, busS.alu_b);
        busL.alu_out = aluOut(busL.alu_func, busL.alu_a, busL.alu_b);
        busL.alu_cmp = aluCmp(busL.alu_func, busL.alu_a, busL.alu_b);
    end

    // Every saturation vector claims 1+1 = 0, so all 300 mismatch.
    always @(posedge clk) begin
        busL.vec_func    <= 5'd0;
        busL.vec_a       <= 32'd1;
        busL.vec_b       <= 32'd1;
        busL.vec_exp_out <= 32'd0;
        busL.vec_exp_cmp <= 1'b0;
        busL.vec_chk_out <= 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic loadGood();
        romFunc[0] = 5'd0;       romA[0] = 32'd2; romB[0] = 32'd3; romExp[0] = 32'd5; romCmp[0] = 1'b0; romChk[0] = 1'b1;
        romFunc[1] = 5'd1;       romA[1] = 32'd5; romB[1] = 32'd2; romExp[1] = 32'd3; romCmp[1] = 1'b0; romChk[1] = 1'b1;
        romFunc[2] = 5'b10001;   romA[2] = 32'd2; romB[2] = 32'd2; romExp[2] = 32'd0; romCmp[2] = 1'b1; romChk[2] = 1'b0;
        romFunc[3] = 5'b10001;   romA[3] = 32'd2; romB[3] = 32'd3; romExp[3] = 32'd0; romCmp[3] = 1'b0; romChk[3] = 1'b0;
    endtask

    task automatic doStart();
        @(negedge clk) startS = 1'b1;
        @(negedge clk) startS = 1'b0;
    endtask

    task automatic waitDone(input int pulseAt, output int cyc);
        cyc = 0;
        while (!doneS && cyc < 200) begin
            @(negedge clk);
            cyc++;
            startS = (cyc == pulseAt);
        end
        startS = 1'b0;
    endtask

    int cyc;

    initial begin
        rst_n  = 1'b0;
        startS = 1'b0;
        startL = 1'b0;
        loadGood();
        repeat (3) @(negedge clk);
        check("rst_busy", busyS, 0);
        check("rst_done", doneS, 0);
        check("rst_pass", passS, 0);
        check("rst_err", errS, 0);
        check("rst_fail", failS, 0);
        check("rst_vecidx", busS.vec_idx, 0);
        check("rst_alu", {busS.alu_func, busS.alu_a, busS.alu_b}, 0);
        rst_n = 1'b1;

        // all-correct run
        doStart();
        check("run1_busy", busyS, 1);
        waitDone(0, cyc);
        check("run1_cycles", cyc, 16);
        check("run1_done", doneS, 1);
        check("run1_busy_end", busyS, 0);
        check("run1_pass", passS, 1);
        check("run1_err", errS, 0);
        check("run1_fail", failS, 0);
        check("run1_vecidx", busS.vec_idx, 3);
        check("run1_alu_hold", {busS.alu_func, busS.alu_a, busS.alu_b}, {5'b10001, 32'd2, 32'd3});

        // wrong compare expectation on vector 2
        romCmp[2] = 1'b0;
        doStart();
        waitDone(0, cyc);
        check("run2_cycles", cyc, FAIL_CYC);
        check("run2_pass", passS, 0);
        check("run2_err", errS, 1);
        check("run2_fail", failS, 2);
`ifdef ALU_BIST_STOP_ON_FAIL_EN
        check("run2_vecidx", busS.vec_idx, 2);
`else
        check("run2_vecidx", busS.vec_idx, 3);
`endif

        // dataOut masked: wrong expected value ignored
        loadGood();
        romExp[2] = 32'hDEADBEEF;
        doStart();
        waitDone(0, cyc);
        check("mask_off_err", errS, 0);
        check("mask_off_pass", passS, 1);

        // same vector with dataOut checked
        romChk[2] = 1'b1;
        doStart();
        waitDone(0, cyc);
        check("mask_on_cycles", cyc, FAIL_CYC);
        check("mask_on_err", errS, 1);
        check("mask_on_fail", failS, 2);
        check("mask_on_pass", passS, 0);

        // restart from DONE clears the previous result
        loadGood();
        doStart();
        check("restart_busy", busyS, 1);
        check("restart_done", doneS, 0);
        check("restart_err", errS, 0);
        check("restart_fail", failS, 0);
        waitDone(0, cyc);
        check("restart_cycles", cyc, 16);
        check("restart_pass", passS, 1);

        // start pulsed mid-run is ignored
        doStart();
        waitDone(5, cyc);
        check("busy_start_cycles", cyc, 16);
        check("busy_start_pass", passS, 1);

        // reset during WAIT of vector 1
        doStart();
        repeat (6) @(negedge clk);
        check("mid_alu_a", busS.alu_a, 5);
        check("mid_vecidx", busS.vec_idx, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_flags", {busyS, doneS, passS}, 0);
        check("midrst_err_fail", {errS, failS}, 0);
        check("midrst_vecidx", busS.vec_idx, 0);
        check("midrst_alu", {busS.alu_func, busS.alu_a, busS.alu_b}, 0);
        rst_n = 1'b1;
        doStart();
        waitDone(0, cyc);
        check("postrst_cycles", cyc, 16);
        check("postrst_pass", passS, 1);
        check("postrst_err", errS, 0);

        // saturation on the 300-vector instance
        @(negedge clk) startL = 1'b1;
        @(negedge clk) startL = 1'b0;
        cyc = 0;
        while (!doneL && cyc < 1500) begin
            @(negedge clk);
            cyc++;
        end
        check("sat_cycles", cyc, SAT_CYC);
        check("sat_err", errL, SAT_ERR);
        check("sat_fail", failL, 0);
        check("sat_pass", passL, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
